riscv_register_file_scrub: RTL and testbench
============================================

// Module: riscv_register_file_scrub
// PURPOSE
//  Flip-flop register file with tag storage: 31 integer registers plus, when FPU=1 and ZFINX=0, 32 FP registers.
//  Provides NUM_RD combinational read ports, two write ports, and a per-register DIFT tag of TAG_WIDTH bits.
//  Contains a sequential scrub engine that walks the file and clears either the tags or data+tags.
//  The scrub is used on context switch or security-domain change.
//  Sits in the ID stage in place of the latch register file; write-back drives ports A (EX) and B (LSU).
// PARAMETERS
//  ADDR_WIDTH  6   register address width; bit 5 selects the FP bank when FPU=1 and ZFINX=0
//  DATA_WIDTH  32  register data width
//  TAG_WIDTH   4   DIFT tag width per register
//  FPU         0   1 = FP bank present
//  ZFINX       0   1 = FP operands use the integer bank (no FP bank)
//  NUM_RD      3   number of read ports (1..4)
// PORTS
//  clk           in   1                     core clock
//  rst_n         in   1                     asynchronous active-low reset
//  raddr_i       in   NUM_RD*ADDR_WIDTH     read addresses; port p = [p*ADDR_WIDTH +: ADDR_WIDTH]
//  rdata_o       out  NUM_RD*DATA_WIDTH     read data, same packing as raddr_i
//  rtag_o        out  NUM_RD*TAG_WIDTH      read tags, same packing as raddr_i
//  we_a_i        in   1                     write enable, port A
//  waddr_a_i     in   ADDR_WIDTH            write address, port A
//  wdata_a_i     in   DATA_WIDTH            write data, port A
//  wtag_a_i      in   TAG_WIDTH             write tag, port A
//  we_b_i, waddr_b_i, wdata_b_i, wtag_b_i   as port A, for port B
//  scrub_req_i   in   1                     single-cycle scrub request
//  scrub_mode_i  in   1                     0 = clear tags only; 1 = clear data and tags
//  scrub_busy_o  out  1                     scrub engine is walking
//  scrub_done_o  out  1                     one-cycle pulse when the scrub completes
// BEHAVIOUR
//  - NUM_TOT = (FPU && !ZFINX) ? 64 : 32. Index 0 is x0: always reads data 0 and tag 0; writes to it are dropped.
//  - Without the FP bank, address bit 5 (if ADDR_WIDTH > 5) is ignored.
//  - Reset: every register data and tag = 0, scrub FSM = IDLE; scrub_busy_o = 0, scrub_done_o = 0.
//    All rdata_o and rtag_o therefore read 0 after reset.
//  - Read: purely combinational from stored state. There is no write-to-read bypass.
//    A value written at edge N is visible after edge N.
//  - Write: captured at posedge clk when we_x_i = 1; data and tag are written together.
//  - Write collision: A and B to the same index in one cycle -> port B wins (data and tag).
//  - Scrub FSM states: IDLE, WALK, DONE.
//    IDLE -> WALK on scrub_req_i = 1. The mode is latched, the index counter is set to 1, and scrub_busy_o = 1 from the next cycle.
//    WALK: each cycle, register[idx] is cleared per the latched mode, then idx increments.
//    When idx = NUM_TOT-1 has been cleared, WALK -> DONE.
//    DONE: scrub_done_o = 1 for exactly one cycle, busy = 0; next state IDLE.
//  - Scrub latency: request at edge N -> done pulse asserted during cycle N+NUM_TOT. That is 31 or 63 WALK cycles plus 1 DONE cycle.
//  - scrub_req_i while in WALK or DONE is ignored; it is not queued.
//  - Architectural write vs scrub on the same index in the same cycle: the write wins and the register holds the written data/tag.
//    Writes to indices already passed by the walk persist. Writes to indices not yet reached are cleared when the walk reaches them.
//  - Mode 0 never modifies data; mode 1 clears data and tag of every index 1..NUM_TOT-1.
//  - Reads remain available during the scrub and return the current (partly cleared) state.
//  - rst_n low mid-scrub: immediately back to IDLE, all state 0, and no done pulse.
//  - Index counter width = ADDR_WIDTH; it never wraps past NUM_TOT-1.
// TESTING
//  1. Reset, then read x1..x31 -> data 0, tag 0. Write x0 = 0xDEADBEEF, tag 0xF -> x0 still reads 0/0.
//  2. Write A and B to x5 in the same cycle (A = 0x11/tag 1, B = 0x22/tag 2) -> next cycle x5 reads 0x22, tag 2.
//  3. FPU=1, ZFINX=0: write f3 (addr 0x23) = 0x3F800000 -> x3 unchanged, f3 reads back correctly.
//     Same write with ZFINX=1 -> x3 = 0x3F800000.
//  4. Fill all registers with tag 0xA, then scrub mode 0 -> scrub_done_o exactly NUM_TOT cycles after the request.
//     All tags are 0 and all data is unchanged. A second request during WALK is ignored.
//  5. Scrub mode 1. Write x31 = 0x55/tag 3 in the same cycle the walk clears x31 -> x31 holds 0x55/3.
//     Write x2 after the walk passes it -> the value persists.
//  6. Deassert rst_n at WALK idx = 10 -> scrub_busy_o = 0, no done pulse, all registers 0; a new request completes normally.

Source files
------------

// File: rtl/riscv_register_file_scrub.sv
// Flip-flop integer/FP register file with per-register DIFT tags and a
// sequential scrub engine that walks the file clearing tags or data+tags.
module riscv_register_file_scrub #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int NUM_RD     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RD*TAG_WIDTH-1:0]  rtag_o,
    input  logic                         we_a_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_a_i,
    input  logic [DATA_WIDTH-1:0]        wdata_a_i,
    input  logic [TAG_WIDTH-1:0]         wtag_a_i,
    input  logic                         we_b_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_b_i,
    input  logic [DATA_WIDTH-1:0]        wdata_b_i,
    input  logic [TAG_WIDTH-1:0]         wtag_b_i,
    input  logic                         scrub_req_i,
    input  logic                         scrub_mode_i,
    output logic                         scrub_busy_o,
    output logic                         scrub_done_o
);

    // state  | meaning
    // S_IDLE | waiting for scrub_req_i
    // S_WALK | clearing register[idx_q] each cycle, idx 1..NUM_TOT-1
    // S_DONE | one-cycle completion pulse, then back to idle

    localparam int NUM_TOT = (FPU != 0 && ZFINX == 0) ? 64 : 32;
    localparam int IDX_W   = (NUM_TOT == 64) ? 6 : 5;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TOT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    mode_q;
    logic [DATA_WIDTH-1:0]   data_q [NUM_TOT];
    logic [TAG_WIDTH-1:0]    tag_q  [NUM_TOT];
    logic [IDX_W-1:0]        widx_a, widx_b, sidx;
    logic                    scrub_act;
    logic                    addr_unused;

    // Without the FP bank the upper address bit simply drops out here.
    assign widx_a    = waddr_a_i[IDX_W-1:0];
    assign widx_b    = waddr_b_i[IDX_W-1:0];
    assign sidx      = idx_q[IDX_W-1:0];
    assign scrub_act = (state_q == S_WALK);
    assign addr_unused = ^{raddr_i, waddr_a_i, waddr_b_i, idx_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (scrub_req_i) state_d = S_WALK;
            S_WALK:  if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scrub_busy_o = 1'b0;
        scrub_done_o = 1'b0;
        case (state_q)
            S_WALK:  scrub_busy_o = 1'b1;
            S_DONE:  scrub_done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mode_q <= 1'b0;
        end else if (state_q == S_IDLE && scrub_req_i) begin
            idx_q  <= ADDR_WIDTH'(1);
            mode_q <= scrub_mode_i;
        end else if (state_q == S_WALK && idx_q != LAST_IDX) begin
            idx_q  <= idx_q + ADDR_WIDTH'(1);
        end
    end

    // Entry 0 is never written after reset, so x0 reads 0/0 for free.
    // Priority per entry: port B, then port A, then the scrub clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TOT; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_TOT; i++) begin
                if (we_b_i && widx_b == IDX_W'(i)) begin
                    data_q[i] <= wdata_b_i;
                    tag_q[i]  <= wtag_b_i;
                end else if (we_a_i && widx_a == IDX_W'(i)) begin
                    data_q[i] <= wdata_a_i;
                    tag_q[i]  <= wtag_a_i;
                end else if (scrub_act && sidx == IDX_W'(i)) begin
                    tag_q[i] <= '0;
                    if (mode_q) data_q[i] <= '0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0] ridx;
        assign ridx = raddr_i[p*ADDR_WIDTH +: IDX_W];
        assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = data_q[ridx];
        assign rtag_o[p*TAG_WIDTH +: TAG_WIDTH]    = tag_q[ridx];
    end

endmodule

// File: tb/tb_riscv_register_file_scrub.sv
// Directed bench: vector table for read/write behaviour, hand sequences for
// scrub latency, write-vs-scrub races and mid-scrub reset.
module tb_riscv_register_file_scrub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] raddr = '0;
    logic [95:0] rdata, rdata_fp, rdata_zx;
    logic [11:0] rtag, rtag_fp, rtag_zx;
    logic        we_a = 1'b0, we_b = 1'b0;
    logic [5:0]  wa_a = '0, wa_b = '0;
    logic [31:0] wd_a = '0, wd_b = '0;
    logic [3:0]  wt_a = '0, wt_b = '0;
    logic        sreq = 1'b0, sreq_fp = 1'b0, sreq_zx = 1'b0, smode = 1'b0;
    logic        busy, done, busy_fp, done_fp, busy_zx, done_zx;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    riscv_register_file_scrub dut (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata), .rtag_o(rtag),
        .we_a_i(we_a), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .wtag_a_i(wt_a),
        .we_b_i(we_b), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .wtag_b_i(wt_b),
        .scrub_req_i(sreq), .scrub_mode_i(smode),
        .scrub_busy_o(busy), .scrub_done_o(done));

    riscv_register_file_scrub #(.FPU(1), .ZFINX(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_fp), .rtag_o(rtag_fp),
        .we_a_i(we_a), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .wtag_a_i(wt_a),
        .we_b_i(we_b), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .wtag_b_i(wt_b),
        .scrub_req_i(sreq_fp), .scrub_mode_i(smode),
        .scrub_busy_o(busy_fp), .scrub_done_o(done_fp));

    riscv_register_file_scrub #(.FPU(1), .ZFINX(1)) dut_zx (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_zx), .rtag_o(rtag_zx),
        .we_a_i(we_a), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .wtag_a_i(wt_a),
        .we_b_i(we_b), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .wtag_b_i(wt_b),
        .scrub_req_i(sreq_zx), .scrub_mode_i(smode),
        .scrub_busy_o(busy_zx), .scrub_done_o(done_zx));

    typedef struct {
        string           nm;
        bit              ea;
        logic [5:0]      aa;
        logic [31:0]     da;
        logic [3:0]      ta;
        bit              eb;
        logic [5:0]      ab;
        logic [31:0]     db;
        logic [3:0]      tb;
        logic [2:0][5:0]  ra;
        logic [2:0][31:0] ed;
        logic [2:0][3:0]  et;
    } vec_t;

    function automatic vec_t mk(string nm, bit ea, logic [5:0] aa, logic [31:0] da, logic [3:0] ta,
                                bit eb, logic [5:0] ab, logic [31:0] db, logic [3:0] tb,
                                logic [5:0] r0, logic [5:0] r1, logic [5:0] r2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [3:0] t0, logic [3:0] t1, logic [3:0] t2);
        vec_t v;
        v.nm = nm; v.ea = ea; v.aa = aa; v.da = da; v.ta = ta;
        v.eb = eb; v.ab = ab; v.db = db; v.tb = tb;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
        v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
        v.et[0] = t0; v.et[1] = t1; v.et[2] = t2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input bit ea, input logic [5:0] aa, input logic [31:0] da, input logic [3:0] ta,
                      input bit eb, input logic [5:0] ab, input logic [31:0] db, input logic [3:0] tb);
        @(negedge clk);
        we_a = ea; wa_a = aa; wd_a = da; wt_a = ta;
        we_b = eb; wa_b = ab; wd_b = db; wt_b = tb;
        @(posedge clk); #1;
        we_a = 1'b0; we_b = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        raddr[5:0] = a;
        #1;
    endtask

    vec_t vt[9];
    int   cyc, dcyc, dcount;

    initial begin
        vt[0] = mk("rst",    0, 6'd0, 32'h0, 4'h0, 0, 6'd0, 32'h0, 4'h0,
                   6'd1, 6'd17, 6'd31, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
        vt[1] = mk("x0wr",   1, 6'd0, 32'hDEADBEEF, 4'hF, 0, 6'd0, 32'h0, 4'h0,
                   6'd0, 6'd0, 6'd1, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
        vt[2] = mk("coll",   1, 6'd5, 32'h11, 4'h1, 1, 6'd5, 32'h22, 4'h2,
                   6'd5, 6'd0, 6'd1, 32'h22, 32'h0, 32'h0, 4'h2, 4'h0, 4'h0);
        vt[3] = mk("wrA",    1, 6'd7, 32'h1234, 4'h5, 0, 6'd0, 32'h0, 4'h0,
                   6'd7, 6'd5, 6'd0, 32'h1234, 32'h22, 32'h0, 4'h5, 4'h2, 4'h0);
        vt[4] = mk("wrAB",   1, 6'd30, 32'hBEEF, 4'h9, 1, 6'd31, 32'hCAFE, 4'hC,
                   6'd31, 6'd30, 6'd7, 32'hCAFE, 32'hBEEF, 32'h1234, 4'hC, 4'h9, 4'h5);
        vt[5] = mk("bit5",   1, 6'h27, 32'h77, 4'h6, 0, 6'd0, 32'h0, 4'h0,
                   6'd7, 6'h27, 6'd5, 32'h77, 32'h77, 32'h22, 4'h6, 4'h6, 4'h2);
        vt[6] = mk("wrAB2",  1, 6'd10, 32'hAAAA, 4'h3, 1, 6'd11, 32'hBBBB, 4'h4,
                   6'd10, 6'd11, 6'd31, 32'hAAAA, 32'hBBBB, 32'hCAFE, 4'h3, 4'h4, 4'hC);
        vt[7] = mk("x0B",    1, 6'd12, 32'h1212, 4'h8, 1, 6'd0, 32'h1, 4'h1,
                   6'd0, 6'd12, 6'd11, 32'h0, 32'h1212, 32'hBBBB, 4'h0, 4'h8, 4'h4);
        vt[8] = mk("weoff",  0, 6'd12, 32'hFFFF, 4'hF, 0, 6'd11, 32'hEEEE, 4'hE,
                   6'd12, 6'd11, 6'd10, 32'h1212, 32'hBBBB, 32'hAAAA, 4'h8, 4'h4, 4'h3);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            we_a = vt[i].ea; wa_a = vt[i].aa; wd_a = vt[i].da; wt_a = vt[i].ta;
            we_b = vt[i].eb; wa_b = vt[i].ab; wd_b = vt[i].db; wt_b = vt[i].tb;
            raddr = vt[i].ra;
            @(posedge clk); #1;
            we_a = 1'b0; we_b = 1'b0;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("%s.d%0d", vt[i].nm, p), rdata[p*32 +: 32], vt[i].ed[p]);
                chk($sformatf("%s.t%0d", vt[i].nm, p), {28'b0, rtag[p*4 +: 4]}, {28'b0, vt[i].et[p]});
            end
        end

        // No write-to-read bypass: new value only after the edge.
        @(negedge clk);
        we_a = 1'b1; wa_a = 6'd12; wd_a = 32'h999; wt_a = 4'h7;
        raddr[5:0] = 6'd12;
        #1;
        chk("nobyp_pre", rdata[31:0], 32'h1212);
        @(posedge clk); #1;
        we_a = 1'b0;
        chk("nobyp_post", rdata[31:0], 32'h999);

        // FP bank addressing.
        wr(1, 6'd3, 32'h3333, 4'h2, 0, 6'd0, 32'h0, 4'h0);
        wr(1, 6'h23, 32'h3F800000, 4'h1, 0, 6'd0, 32'h0, 4'h0);
        rd(6'd3);
        chk("fp_x3", rdata_fp[31:0], 32'h3333);
        chk("fp_x3t", {28'b0, rtag_fp[3:0]}, 32'h2);
        chk("zx_x3", rdata_zx[31:0], 32'h3F800000);
        chk("nofp_x3", rdata[31:0], 32'h3F800000);
        rd(6'h23);
        chk("fp_f3", rdata_fp[31:0], 32'h3F800000);
        chk("fp_f3t", {28'b0, rtag_fp[3:0]}, 32'h1);

        // Fill x1..x31 with tag A, then tag-only scrub.
        for (int i = 1; i < 32; i++)
            wr(1, 6'(i), 32'h1000 + i, 4'hA, 0, 6'd0, 32'h0, 4'h0);
        @(negedge clk);
        sreq = 1'b1; smode = 1'b0;
        #1;
        chk("s0_busy_pre", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        cyc = 1; dcyc = 0; dcount = 0;
        chk("s0_busy1", {31'b0, busy}, 32'h1);
        while (cyc < 100) begin
            if (done) begin dcount++; if (dcyc == 0) dcyc = cyc; end
            if (cyc == 10) begin
                rd(6'd5);
                chk("s0_mid_x5t", {28'b0, rtag[3:0]}, 32'h0);
                chk("s0_mid_x5d", rdata[31:0], 32'h1005);
                rd(6'd20);
                chk("s0_mid_x20t", {28'b0, rtag[3:0]}, 32'hA);
            end
            if (cyc == 31) chk("s0_busy31", {31'b0, busy}, 32'h1);
            if (cyc == 32) chk("s0_busy32", {31'b0, busy}, 32'h0);
            @(negedge clk);
            sreq = (cyc == 5 || cyc == 32);
            @(posedge clk); #1;
            cyc++;
        end
        sreq = 1'b0;
        chk("s0_latency", dcyc, 32);
        chk("s0_ndone", dcount, 1);
        chk("s0_idle", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd(6'(i));
            chk($sformatf("s0_x%0d_d", i), rdata[31:0], (i == 0) ? 32'h0 : 32'h1000 + i);
            chk($sformatf("s0_x%0d_t", i), {28'b0, rtag[3:0]}, 32'h0);
        end

        // FP-bank instance: 64-entry walk, data+tag.
        @(negedge clk);
        sreq_fp = 1'b1; smode = 1'b1;
        @(posedge clk); #1;
        sreq_fp = 1'b0;
        cyc = 1; dcyc = 0; dcount = 0;
        while (cyc < 150) begin
            if (done_fp) begin dcount++; if (dcyc == 0) dcyc = cyc; end
            @(posedge clk); #1;
            cyc++;
        end
        chk("fp_latency", dcyc, 64);
        chk("fp_ndone", dcount, 1);
        rd(6'h23);
        chk("fp_f3_clr", rdata_fp[31:0], 32'h0);
        rd(6'd3);
        chk("fp_x3_clr", rdata_fp[31:0], 32'h0);
        chk("fp_main_x3", rdata[31:0], 32'h1003);

        // Data+tag scrub on the main file with racing writes.
        @(negedge clk);
        sreq = 1'b1; smode = 1'b1;
        @(posedge clk); #1;
        sreq = 1'b0;
        cyc = 1; dcyc = 0; dcount = 0;
        while (cyc < 100) begin
            if (done) begin dcount++; if (dcyc == 0) dcyc = cyc; end
            @(negedge clk);
            if (cyc == 5) begin
                we_a = 1'b1; wa_a = 6'd2;  wd_a = 32'h2222; wt_a = 4'h7;
                we_b = 1'b1; wa_b = 6'd20; wd_b = 32'h2020; wt_b = 4'h1;
            end
            if (cyc == 31) begin
                we_a = 1'b1; wa_a = 6'd31; wd_a = 32'h55; wt_a = 4'h3;
            end
            @(posedge clk); #1;
            we_a = 1'b0; we_b = 1'b0;
            cyc++;
        end
        chk("s1_latency", dcyc, 32);
        chk("s1_ndone", dcount, 1);
        rd(6'd2);
        chk("s1_x2_d", rdata[31:0], 32'h2222);
        chk("s1_x2_t", {28'b0, rtag[3:0]}, 32'h7);
        rd(6'd31);
        chk("s1_x31_d", rdata[31:0], 32'h55);
        chk("s1_x31_t", {28'b0, rtag[3:0]}, 32'h3);
        rd(6'd20);
        chk("s1_x20_d", rdata[31:0], 32'h0);
        chk("s1_x20_t", {28'b0, rtag[3:0]}, 32'h0);
        rd(6'd16);
        chk("s1_x16_d", rdata[31:0], 32'h0);

        // Reset mid-walk, then a fresh scrub.
        @(negedge clk);
        sreq = 1'b1; smode = 1'b0;
        @(posedge clk); #1;
        sreq = 1'b0;
        cyc = 1; dcount = 0;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_mid_busy_pre", {31'b0, busy}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        rd(6'd2);
        chk("rst_mid_x2", rdata[31:0], 32'h0);
        rd(6'd31);
        chk("rst_mid_x31t", {28'b0, rtag[3:0]}, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("rst_mid_nodone", dcount, 0);
        @(negedge clk);
        sreq = 1'b1; smode = 1'b1;
        @(posedge clk); #1;
        sreq = 1'b0;
        cyc = 1; dcyc = 0;
        while (cyc < 100 && dcyc == 0) begin
            if (done) dcyc = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("rst_rescrub_lat", dcyc, 32);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
